// File: rtl/l1_buffer_addr_ctrl_if.sv
// l1_buffer_addr_ctrl_if: control, SRAM and event-FIFO signals of the L1 buffer controller
interface l1_buffer_addr_ctrl_if #(
  parameter int ADDRWIDTH  = 7,
  parameter int L1CNTWIDTH = 8
);
  logic                  enable;
  logic [ADDRWIDTH-1:0]  latency;
  logic                  L1A;
  logic                  wren;
  logic [ADDRWIDTH-1:0]  wrAddr;
  logic                  rden;
  logic [ADDRWIDTH-1:0]  rdAddr;
  logic                  sramHit;
  logic                  evtValid;
  logic                  evtReady;
  logic                  evtHit;
  logic [L1CNTWIDTH-1:0] evtL1Cnt;
  logic [L1CNTWIDTH-1:0] l1Cnt;
  logic                  overflow;
  logic [7:0]            dropCnt;
  modport master (
    output enable, latency, L1A, sramHit, evtReady,
    input  wren, wrAddr, rden, rdAddr, evtValid, evtHit, evtL1Cnt, l1Cnt, overflow, dropCnt
  );
  modport slave (
    input  enable, latency, L1A, sramHit, evtReady,
    output wren, wrAddr, rden, rdAddr, evtValid, evtHit, evtL1Cnt, l1Cnt, overflow, dropCnt
  );
endinterface

// File: rtl/l1_buffer_addr_ctrl.sv
// l1_buffer_addr_ctrl: circular write addressing, L1A-triggered reads and a 4-deep event FIFO
module l1_buffer_addr_ctrl #(
  parameter int ADDRWIDTH  = 7,
  parameter int L1CNTWIDTH = 8
) (
  input logic clk,
  input logic reset,
  l1_buffer_addr_ctrl_if.slave bus
);
  logic [3:0]                 fh;
  logic [3:0][L1CNTWIDTH-1:0] ft;
  logic [1:0]                 wp, rp;
  logic [2:0]                 cnt;
  logic [L1CNTWIDTH-1:0]      tag;
  logic                       fire, acc, pop;
  assign bus.evtValid = cnt != 3'd0;
  assign bus.evtHit   = fh[rp];
  assign bus.evtL1Cnt = ft[rp];
  // a trigger is accepted only if the FIFO can hold it alongside the read still in flight
  always_comb begin
    fire = bus.L1A & bus.enable;
    acc  = fire & (cnt + 3'(bus.rden) < 3'd4);
    pop  = bus.evtValid & bus.evtReady;
  end
  // write pointer, trigger pipeline, drop accounting and FIFO state
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wren     <= 1'b0;
      bus.wrAddr   <= '0;
      bus.rden     <= 1'b0;
      bus.rdAddr   <= '0;
      bus.l1Cnt    <= '0;
      bus.overflow <= 1'b0;
      bus.dropCnt  <= '0;
      tag          <= '0;
      fh           <= '0;
      ft           <= '0;
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
    end else begin
      bus.wren <= bus.enable;
      if (bus.wren) bus.wrAddr <= bus.wrAddr + ADDRWIDTH'(1);
      if (fire) bus.l1Cnt <= bus.l1Cnt + L1CNTWIDTH'(1);
      if (fire & ~acc) begin
        bus.overflow <= 1'b1;
        bus.dropCnt  <= bus.dropCnt + 8'(bus.dropCnt != 8'hff);
      end
      bus.rden <= acc;
      if (acc) begin
        bus.rdAddr <= bus.wrAddr - bus.latency;
        tag        <= bus.l1Cnt;
      end
      if (bus.rden) begin
        fh[wp] <= bus.sramHit;
        ft[wp] <= tag;
        wp     <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + 3'(bus.rden) - 3'(pop);
    end
  end
endmodule
